// File: rtl/key_pkg.sv
// Shared types and constants for the key-driven interval tick scheduler.
package key_pkg;

   localparam int unsigned N_INTERVALS = 4;
   localparam int unsigned SEL_W       = 2;
   localparam int unsigned MS_W        = 16;
   localparam int unsigned TICK_CNT_W  = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2
   } state_e;

   // Element [i] is the tick period in ms for interval_sel == i.
   typedef logic [N_INTERVALS-1:0][MS_W-1:0] interval_tbl_t;

   // Concatenation fills from the top index down: [3]=1000 ... [0]=100.
   localparam interval_tbl_t INTERVAL_MS_DEF = {16'd1000, 16'd500, 16'd250, 16'd100};

endpackage

// File: rtl/key_sched_if.sv
// Key pulses in, scheduler status out; the driver side is master.
interface key_sched_if;
   import key_pkg::*;

   logic                  key0;
   logic                  key_interval;
   logic                  running;
   logic                  paused;
   logic [SEL_W-1:0]      interval_sel;
   logic                  tick;
   logic [TICK_CNT_W-1:0] tick_cnt;

   modport master (
      output key0, key_interval,
      input  running, paused, interval_sel, tick, tick_cnt
   );

   modport slave (
      input  key0, key_interval,
      output running, paused, interval_sel, tick, tick_cnt
   );

endinterface

// File: rtl/ms_timebase.sv
// Prescaler producing a one-cycle strobe every PRESCALE enabled cycles.
module ms_timebase #(
   parameter int unsigned PRESCALE = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic clr_i,
   output logic ms_stb_c_o
);

   localparam int unsigned PC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PC_W-1:0] PC_MAX = PC_W'(PRESCALE - 1);

   logic [PC_W-1:0] pc_q, pc_d;

   always_comb begin
      pc_d = pc_q;
      if (clr_i) begin
         pc_d = '0;
      end else if (en_i) begin
         pc_d = (pc_q == PC_MAX) ? '0 : pc_q + PC_W'(1);
      end
   end

   assign ms_stb_c_o = en_i && !clr_i && (pc_q == PC_MAX);

   always_ff @(posedge clk) begin
      if (rst) pc_q <= '0;
      else     pc_q <= pc_d;
   end

endmodule

// File: rtl/key_sched.sv
// Start/stop/pause scheduler emitting a tick every INTERVAL_MS[sel] ms,
// with a wrapping tick counter; controlled by two debounced key pulses.
module key_sched
   import key_pkg::*;
#(
   parameter int unsigned   PRESCALE    = 50000,
   parameter interval_tbl_t INTERVAL_MS = INTERVAL_MS_DEF
) (
   input logic        clk,
   input logic        rst,
   key_sched_if.slave bus
);

   localparam logic [1:0] IDLE  = S_IDLE;
   localparam logic [1:0] RUN   = S_RUN;
   localparam logic [1:0] PAUSE = S_PAUSE;
   localparam int unsigned MSX_W = MS_W + 1;

   logic [1:0]            state_q, state_d;
   logic [SEL_W-1:0]      sel_q, sel_d;
   logic [MS_W-1:0]       ms_q, ms_d;
   logic [TICK_CNT_W-1:0] cnt_q, cnt_d;
   logic                  tick_q, tick_d;
   logic                  running_q, paused_q;

   logic                  tb_en_c, tb_clr_c, ms_stb_c;
   logic [MS_W-1:0]       lim_c;
   logic                  ms_last_c;

   // A cycle carrying any key event leaves RUN or restarts the count, so it never advances time.
   assign tb_en_c   = (state_q == RUN) && !bus.key0 && !bus.key_interval;
   assign lim_c     = INTERVAL_MS[sel_q];
   assign ms_last_c = (MSX_W'(ms_q) + MSX_W'(1)) >= MSX_W'(lim_c);

   ms_timebase #(.PRESCALE(PRESCALE)) u_timebase (
      .clk        (clk),
      .rst        (rst),
      .en_i       (tb_en_c),
      .clr_i      (tb_clr_c),
      .ms_stb_c_o (ms_stb_c)
   );

   // Next-state, counters and tick generation.
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      ms_d     = ms_q;
      cnt_d    = cnt_q;
      tick_d   = 1'b0;
      tb_clr_c = 1'b0;

      if (bus.key0 && bus.key_interval) begin
         state_d  = IDLE;
         ms_d     = '0;
         cnt_d    = '0;
         tb_clr_c = 1'b1;
      end else if (bus.key_interval) begin
         sel_d    = sel_q + SEL_W'(1);
         ms_d     = '0;
         tb_clr_c = 1'b1;
      end else if (bus.key0) begin
         case (state_q)
            IDLE: begin
               state_d  = RUN;
               ms_d     = '0;
               cnt_d    = '0;
               tb_clr_c = 1'b1;
            end
            RUN:     state_d = PAUSE;
            PAUSE:   state_d = RUN;
            default: state_d = IDLE;
         endcase
      end else if (ms_stb_c) begin
         if (ms_last_c) begin
            ms_d   = '0;
            tick_d = 1'b1;
            cnt_d  = cnt_q + TICK_CNT_W'(1);
         end else begin
            ms_d = ms_q + MS_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         sel_q     <= '0;
         ms_q      <= '0;
         cnt_q     <= '0;
         tick_q    <= 1'b0;
         running_q <= 1'b0;
         paused_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         ms_q      <= ms_d;
         cnt_q     <= cnt_d;
         tick_q    <= tick_d;
         running_q <= (state_d == RUN);
         paused_q  <= (state_d == PAUSE);
      end
   end

   assign bus.running      = running_q;
   assign bus.paused       = paused_q;
   assign bus.interval_sel = sel_q;
   assign bus.tick         = tick_q;
   assign bus.tick_cnt     = cnt_q;

endmodule

// File: doc/key_sched.md
KEY_SCHED -- requirements
Module: key_sched

Interface
REQ-001 Parameter PRESCALE, default 50000, SHALL set clk cycles per 1 ms timebase strobe (50 MHz board clock).
REQ-002 Parameter INTERVAL_MS, default pkg table {100,250,500,1000}, SHALL give tick period in ms for interval_sel 0..3.
REQ-003 Port list SHALL be as follows:
- clk  in  1  single system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- key0  in  1  one-cycle start/stop pulse from the debouncer.
- key_interval  in  1  one-cycle "next interval" pulse from the debouncer.
- running  out  1  high in RUN.
- paused  out  1  high in PAUSE.
- interval_sel  out  2  current interval index.
- tick  out  1  one-cycle pulse per elapsed interval.
- tick_cnt  out  8  count of ticks since last clear.

Function
REQ-004 FSM SHALL have states IDLE, RUN, PAUSE.
REQ-005 key0 alone SHALL cause the following transitions:
- IDLE->RUN, clearing prescale counter, ms counter and tick_cnt.
- RUN->PAUSE.
- PAUSE->RUN.
REQ-006 The new state SHALL be visible on running/paused the cycle after the key0 pulse.
REQ-007 key0 and key_interval high in the same cycle SHALL force IDLE from any state, clear all counters, and leave interval_sel unchanged.
REQ-008 key_interval alone SHALL advance interval_sel modulo 4 (3->0) in every state and SHALL clear the prescale and ms counters; tick_cnt SHALL be unaffected.
REQ-009 Prescale counter SHALL count 0..PRESCALE-1 only in RUN, producing an internal ms strobe at PRESCALE-1.
REQ-010 ms counter SHALL count strobes 0..INTERVAL_MS[interval_sel]-1, then wrap to 0.
REQ-011 The wrap of REQ-010 SHALL assert tick for exactly one cycle.
REQ-012 First tick after entering RUN from IDLE, or after an interval change in RUN, SHALL occur exactly PRESCALE*INTERVAL_MS[sel] cycles after the state/selection takes effect; the cycle count restarts from the edge on which the change takes effect.
REQ-013 In PAUSE both counters SHALL hold; on resume, counting SHALL continue from the held values, with no tick lost or duplicated.
REQ-014 tick SHALL never assert in IDLE or PAUSE.
REQ-015 tick_cnt SHALL increment on each tick and wrap 255->0.
REQ-016 All outputs SHALL be registered; no combinational path from key inputs to outputs.
REQ-017 Pulses longer than one cycle are out of contract; each high cycle SHALL count as a separate event.

Reset
REQ-018 While rst is high at a clk edge, the block SHALL enter IDLE with:
- running=0, paused=0, tick=0
- interval_sel=0, tick_cnt=0
- all counters at 0
REQ-019 rst SHALL override any simultaneous key event, including mid-interval and during PAUSE.

Structure
REQ-020 Shared package key_pkg SHALL hold the state enum (IDLE, RUN, PAUSE) and the default INTERVAL_MS table constant.
REQ-021 The PRESCALE counter with its ms strobe SHALL be the sub-module ms_timebase, with enable and sync clear inputs.
REQ-022 FSM, ms counter and tick counter SHALL reside in key_sched.

Verification (PRESCALE=2, default table)
REQ-023 Reset, then key0 at cycle 0 -> running=1 from cycle 1; first tick at cycle 201; tick_cnt=1.
REQ-024 RUN 150 cycles, key0, wait 1000, key0 -> no tick while paused; next tick 50 run-cycles after resume.
REQ-025 In RUN, four key_interval pulses -> interval_sel 1,2,3,0; after the last pulse the next tick comes 200 cycles later.
REQ-026 Run at sel=0 for 256 ticks -> tick_cnt wraps to 0; tick width exactly 1 cycle each time.
REQ-027 key0 and key_interval simultaneous in RUN -> IDLE, tick_cnt=0, interval_sel unchanged, no further ticks.
REQ-028 rst asserted mid-PAUSE with key0 in the same cycle -> all outputs at reset values next cycle; state IDLE.
